// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit-side FIFO and dispatcher.
package uart_tx_fifo_pkg;

    // Width of one UART payload byte.
    localparam int unsigned UART_BYTE_W = 8;

    // Transmitter clocks per bit; the transmitter instance must use the same value.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 521;

    // Dispatcher states: IDLE waits for a byte and a free transmitter,
    // WAIT holds the presented byte until the frame completes.
    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } disp_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo_8b.sv
// Generic synchronous byte FIFO with registered occupancy and overflow pulse.
module uart_tx_fifo_sync_fifo_8b
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_uart_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    output logic [UART_BYTE_W-1:0] rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   overflow_q;
    logic                   pop_ok;
    logic                   push_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // A pop from a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk_uart_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy and the dropped-push flag.
    always_ff @(posedge clk_uart_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_i && full_o && !pop_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus dispatcher feeding a UART transmitter, with a done-watchdog.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic                   clk_uart_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [UART_BYTE_W-1:0] wr_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   timeout_o,
    output logic                   tx_dv_o,
    output logic [UART_BYTE_W-1:0] tx_byte_o,
    input  logic                   tx_active_i,
    input  logic                   tx_done_i,
    output logic                   busy_o
);

    localparam int unsigned WDW = $clog2(TIMEOUT_CLKS) + 1;

    disp_state_e            state_q;
    logic [WDW-1:0]         wd_cnt_q;
    logic                   tx_dv_q;
    logic [UART_BYTE_W-1:0] tx_byte_q;
    logic                   timeout_q;
    logic                   pop;
    logic                   fifo_empty;
    logic [UART_BYTE_W-1:0] fifo_rd_data;

    assign pop = (state_q == StIdle) && !fifo_empty && !tx_active_i;

    uart_tx_fifo_sync_fifo_8b #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_uart_i(clk_uart_i),
        .rst_i     (rst_i),
        .push_i    (wr_en_i),
        .pop_i     (pop),
        .wr_data_i (wr_data_i),
        .rd_data_o (fifo_rd_data),
        .full_o    (full_o),
        .empty_o   (fifo_empty),
        .count_o   (count_o),
        .overflow_o(overflow_o)
    );

    // Dispatcher: present one byte, hold it for the frame, await done or watchdog.
    always_ff @(posedge clk_uart_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            wd_cnt_q  <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tx_dv_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_byte_q <= fifo_rd_data;
                        tx_dv_q   <= 1'b1;
                        wd_cnt_q  <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (tx_done_i) begin
                        state_q <= StIdle;
                    end else if (wd_cnt_q == WDW'(TIMEOUT_CLKS - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WDW'(1);
                    end
                end
            endcase
        end
    end

    assign tx_dv_o   = tx_dv_q;
    assign tx_byte_o = tx_byte_q;
    assign timeout_o = timeout_q;
    assign empty_o   = fifo_empty;
    assign busy_o    = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-based reference model
// and a simple behavioural transmitter.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CPB   = 4;
    localparam int unsigned TMO   = 60;
    localparam int          FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, timeout, tx_dv, busy;
    logic [2:0] count;
    logic [7:0] tx_byte;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_uart_i (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow),
        .timeout_o  (timeout),
        .tx_dv_o    (tx_dv),
        .tx_byte_o  (tx_byte),
        .tx_active_i(tx_active),
        .tx_done_i  (tx_done),
        .busy_o     (busy)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued bytes plus "a byte is in flight since cycle m_disp".
    logic [7:0] exp_q[$];
    bit         m_wait;
    int         m_disp;
    int         cyc;
    logic [7:0] m_byte;
    bit         m_dv, m_ovf, m_to;

    // Behavioural transmitter.
    int tx_rem    = 0;
    bit hang      = 0;
    bit hold_busy = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_wait = 0;
        m_byte = 8'h00;
        m_dv   = 0;
        m_ovf  = 0;
        m_to   = 0;
    endtask

    task automatic tx_refresh();
        tx_active = (tx_rem > 0) || hold_busy;
    endtask

    task automatic check_outputs();
        check("tx_dv", 32'(tx_dv), 32'(m_dv));
        check("tx_byte", 32'(tx_byte), 32'(m_byte));
        check("count", 32'(count), 32'(exp_q.size()));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("timeout", 32'(timeout), 32'(m_to));
        check("busy", 32'(busy), 32'(exp_q.size() != 0 || m_wait));
    endtask

    // One clock: drive a push request, advance model and transmitter, check.
    task automatic tick(input bit we, input logic [7:0] wd);
        bit dv_pre, act_pre, done_pre, pop;
        int sz;
        wr_en    = we;
        wr_data  = wd;
        dv_pre   = tx_dv;
        act_pre  = tx_active;
        done_pre = tx_done;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            m_dv  = 0;
            m_ovf = 0;
            m_to  = 0;
            sz    = exp_q.size();
            pop   = !m_wait && sz > 0 && !act_pre;
            if (pop) begin
                m_byte = exp_q.pop_front();
                m_dv   = 1;
                m_wait = 1;
                m_disp = cyc;
            end else if (m_wait) begin
                if (done_pre) m_wait = 0;
                else if (cyc - m_disp == TMO) begin
                    m_to   = 1;
                    m_wait = 0;
                end
            end
            if (we) begin
                if (sz < DEPTH || pop) exp_q.push_back(wd);
                else m_ovf = 1;
            end
        end
        tx_done = 1'b0;
        if (tx_rem > 0) begin
            tx_rem--;
            if (tx_rem == 0) tx_done = !hang;
        end else if (dv_pre) begin
            tx_rem = FRAME;
        end
        tx_refresh();
        wr_en = 1'b0;
        check_outputs();
    endtask

    task automatic run_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !m_wait && tx_rem == 0) break;
            tick(0, 8'h00);
        end
        check("drained", 32'(busy), 32'(0));
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #2;
        check_outputs();
        tick(0, 8'h00);
        tick(0, 8'h00);
        rst = 1'b0;

        // Single byte at cycle 10.
        while (cyc < 9) tick(0, 8'h00);
        tick(1, 8'h41);
        run_idle(200);

        // Burst "Hi!".
        tick(1, 8'h48);
        tick(1, 8'h69);
        tick(1, 8'h21);
        run_idle(400);

        // Overflow with the transmitter held busy.
        hold_busy = 1;
        tx_refresh();
        for (int i = 0; i < 5; i++) tick(1, 8'hA0 + 8'(i));
        tick(0, 8'h00);
        hold_busy = 0;
        tx_refresh();
        run_idle(400);

        // Push into a full FIFO on the cycle of a pop.
        hold_busy = 1;
        tx_refresh();
        for (int i = 0; i < 4; i++) tick(1, 8'hB0 + 8'(i));
        tick(0, 8'h00);
        hold_busy = 0;
        tx_refresh();
        tick(1, 8'h55);
        run_idle(400);

        // Watchdog: transmitter never reports done.
        hang = 1;
        tick(1, 8'hC1);
        tick(1, 8'hC2);
        run_idle(400);
        hang = 0;

        // Randomised traffic with occasional stalls and hangs.
        for (int seg = 0; seg < 6; seg++) begin
            hold_busy = ($urandom_range(0, 3) == 0);
            hang      = ($urandom_range(0, 3) == 0);
            tx_refresh();
            for (int i = 0; i < 250; i++) begin
                tick($urandom_range(0, 5) == 0, 8'($urandom));
            end
        end
        hold_busy = 0;
        hang      = 0;
        tx_refresh();
        run_idle(2000);

        // Asynchronous reset mid-frame with three bytes still queued.
        for (int i = 0; i < 4; i++) tick(1, 8'hD0 + 8'(i));
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_empty", 32'(empty), 32'(1));
        check("rst_async_count", 32'(count), 32'(0));
        check("rst_async_dv", 32'(tx_dv), 32'(0));
        check("rst_async_byte", 32'(tx_byte), 32'(0));
        model_reset();
        tick(0, 8'h00);
        tick(0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick(0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
